// File: rtl/dut_pipe_misr.sv
// dut_pipe_misr: two-stage valid/ready pipeline around a configurable logic cone,
// with an optional MISR that compresses each window of NUM_VEC results into one signature.
// Define DUT_MISR_EN to build the MISR and window FSM; otherwise sig_valid, sig_out
// and vec_cnt are tied to zero and only the pipeline is built.
module dut_pipe_misr #(
  parameter int unsigned     IN_W      = 50,
  parameter int unsigned     OUT_W     = 30,
  parameter int unsigned     NUM_VEC   = 16,
  parameter logic [OUT_W-1:0] MISR_POLY = 30'h20000029,
  parameter logic [OUT_W-1:0] CONST_VAL = '0,
  localparam int unsigned    CNT_W     = $clog2(NUM_VEC + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             sig_valid,
  output logic [OUT_W-1:0] sig_out,
  output logic [CNT_W-1:0] vec_cnt
);

  logic             s1_valid_q;
  logic [IN_W-1:0]  s1_data_q;
  logic             s2_valid_q;
  logic [OUT_W-1:0] s2_data_q;
  logic [OUT_W-1:0] cone_res;
  logic             stall;
  logic             in_hs;

  // Each result bit looks at three consecutive input bits, wrapping around the input.
  for (genvar i = 0; i < OUT_W; i++) begin : g_cone
    localparam int unsigned IA = (3 * i) % IN_W;
    localparam int unsigned IB = (3 * i + 1) % IN_W;
    localparam int unsigned IC = (3 * i + 2) % IN_W;
    assign cone_res[i] = (s1_data_q[IA] & s1_data_q[IB]) ^ s1_data_q[IC] ^ CONST_VAL[i];
  end

  // Whole pipeline freezes while the result is held by the consumer.
  assign stall     = s2_valid_q & ~out_ready;
  assign in_ready  = rst_n & ~stall;
  assign in_hs     = in_valid & in_ready;
  assign out_valid = s2_valid_q;
  assign out       = s2_data_q;

  // Pipeline stage registers: S1 captures input, S2 captures cone result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_hs;
      if (in_hs) s1_data_q <= in;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_data_q <= cone_res;
    end
  end

`ifdef DUT_MISR_EN
  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] sig_q, sig_d;
  logic [OUT_W-1:0] sig_out_q, sig_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_hs;
  logic [OUT_W-1:0] sig_base;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] misr_upd;

  assign out_hs = s2_valid_q & out_ready;

  // Outside ACCUM a handshake opens a fresh window, so it seeds from zero.
  always_comb begin
    sig_base = (state_q == StAccum) ? sig_q : '0;
    cnt_inc  = ((state_q == StAccum) ? cnt_q : '0) + CNT_W'(1);
    misr_upd = {sig_base[OUT_W-2:0], 1'b0} ^ (sig_base[OUT_W-1] ? MISR_POLY : '0) ^ s2_data_q;
  end

  // Window FSM next-state: accumulate handshakes, report once per window.
  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    sig_out_d = sig_out_q;
    cnt_d     = cnt_q;
    if (out_hs) begin
      sig_d = misr_upd;
      cnt_d = cnt_inc;
      if (cnt_inc == CNT_W'(NUM_VEC)) begin
        state_d   = StDone;
        sig_out_d = misr_upd;
      end else begin
        state_d = StAccum;
      end
    end else begin
      unique case (state_q)
        StAccum: state_d = StAccum;
        StDone, StIdle: begin
          state_d = StIdle;
          sig_d   = '0;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          sig_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Window FSM state, accumulator, counter and held signature.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sig_q     <= '0;
      sig_out_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      sig_out_q <= sig_out_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sig_valid = (state_q == StDone);
  assign sig_out   = sig_out_q;
  assign vec_cnt   = cnt_q;
`else
  assign sig_valid = 1'b0;
  assign sig_out   = '0;
  assign vec_cnt   = '0;
`endif

endmodule

// File: tb/tb_dut_pipe_misr.sv
// Directed, table-driven bench for dut_pipe_misr (NUM_VEC=2) with a result scoreboard.
module tb_dut_pipe_misr;
  localparam int IN_W    = 50;
  localparam int OUT_W   = 30;
  localparam int NUM_VEC = 2;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  din = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] dout;
  logic             sig_valid;
  logic [OUT_W-1:0] sig_out;
  logic [CNT_W-1:0] vec_cnt;

  typedef struct {
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dout;
  } vec_t;

  vec_t             tbl[12];
  logic [OUT_W-1:0] exp_q[$];
  int               n_tests = 0;
  int               n_fail = 0;
  int               n_rx = 0;
  int               sig_pulses = 0;

  dut_pipe_misr #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NUM_VEC),
    .MISR_POLY(30'h20000029), .CONST_VAL(30'h0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(din),
    .out_valid(out_valid), .out_ready(out_ready), .out(dout),
    .sig_valid(sig_valid), .sig_out(sig_out), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: in_ready vs stall, in-order result data, signature pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready_vs_stall", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        n_rx++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h, no result expected", dout);
        end else begin
          check("out_data", 64'(dout), 64'(exp_q.pop_front()));
        end
      end
      if (sig_valid) sig_pulses++;
`ifndef DUT_MISR_EN
      check("sig_valid_tied", 64'(sig_valid), 64'(0));
      check("sig_out_tied", 64'(sig_out), 64'(0));
      check("vec_cnt_tied", 64'(vec_cnt), 64'(0));
`endif
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    din = '1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    sig_pulses = 0;
    n_rx = 0;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out", 64'(dout), 64'(0));
    check("rst_sig_valid", 64'(sig_valid), 64'(0));
    check("rst_sig_out", 64'(sig_out), 64'(0));
    check("rst_vec_cnt", 64'(vec_cnt), 64'(0));
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Streams tbl[first +: n]; with bp set, out_ready follows 1,0,0,1 per cycle.
  task automatic run_stream(input int first, input int n, input bit bp);
    int idx = 0;
    int cyc = 0;
    int guard = 0;
    int rx0 = n_rx;
    while (idx < n && guard < 200) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      in_valid = 1'b1;
      din = tbl[first + idx].din;
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(tbl[first + idx].dout);
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    out_ready = 1'b1;
    check("stream_accepted", 64'(idx), 64'(n));
    check("stream_drained", 64'(exp_q.size()), 64'(0));
    check("stream_rx_count", 64'(n_rx - rx0), 64'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{50'h4,             30'h1};
    tbl[1]  = '{{IN_W{1'b1}},      30'h0};
    tbl[2]  = '{50'h0,             30'h0};
    tbl[3]  = '{50'h4,             30'h1};
    tbl[4]  = '{50'h20,            30'h2};
    tbl[5]  = '{50'h100,           30'h4};
    tbl[6]  = '{50'h1,             30'h10000};
    tbl[7]  = '{50'h3,             30'h10001};
    tbl[8]  = '{50'h7,             30'h30000};
    tbl[9]  = '{50'h100000,        30'h40};
    tbl[10] = '{50'h1000,          30'h100000};
    tbl[11] = '{50'h8000000000,    30'h20000000};

    do_reset();

    // Cone values and two-cycle latency, one isolated vector at a time.
    for (int k = 0; k < 3; k++) begin
      din = tbl[k].din;
      in_valid = 1'b1;
      exp_q.push_back(tbl[k].dout);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_cycle1_valid", 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      check("lat_cycle2_valid", 64'(out_valid), 64'(1));
      check("cone_out", 64'(dout), 64'(tbl[k].dout));
      @(posedge clk); #1;
    end

    // Backpressure stream, then a full-rate stream of the same vectors.
    do_reset();
    run_stream(3, 8, 1'b1);
    run_stream(3, 8, 1'b0);

`ifdef DUT_MISR_EN
    // Partial window interrupted by reset must leave nothing behind.
    do_reset();
    din = tbl[0].din;
    in_valid = 1'b1;
    exp_q.push_back(tbl[0].dout);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("partial_vec_cnt", 64'(vec_cnt), 64'(1));
    do_reset();

    // One window of two 50'h4 vectors: signature 1 then 3.
    din = 50'h4;
    in_valid = 1'b1;
    exp_q.push_back(30'h1);
    exp_q.push_back(30'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("w1_cnt_c2", 64'(vec_cnt), 64'(0));
    @(posedge clk); #1;
    check("w1_cnt_c3", 64'(vec_cnt), 64'(1));
    check("w1_sigv_c3", 64'(sig_valid), 64'(0));
    @(posedge clk); #1;
    check("w1_cnt_c4", 64'(vec_cnt), 64'(2));
    check("w1_sigv_c4", 64'(sig_valid), 64'(1));
    check("w1_sig_c4", 64'(sig_out), 64'(30'h3));
    @(posedge clk); #1;
    check("w1_sigv_c5", 64'(sig_valid), 64'(0));
    check("w1_cnt_c5", 64'(vec_cnt), 64'(0));
    check("w1_sig_hold", 64'(sig_out), 64'(30'h3));
    check("w1_pulses", 64'(sig_pulses), 64'(1));

    // Back-to-back windows: {2,1} -> 5, then {2^29,2^29} -> 0x29 via the taps.
    do_reset();
    in_valid = 1'b1;
    din = tbl[4].din;  exp_q.push_back(tbl[4].dout);
    @(posedge clk); #1;
    din = tbl[0].din;  exp_q.push_back(tbl[0].dout);
    @(posedge clk); #1;
    din = tbl[11].din; exp_q.push_back(tbl[11].dout);
    @(posedge clk); #1;
    din = tbl[11].din; exp_q.push_back(tbl[11].dout);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("w2a_sigv", 64'(sig_valid), 64'(1));
    check("w2a_sig", 64'(sig_out), 64'(30'h5));
    check("w2a_cnt", 64'(vec_cnt), 64'(2));
    @(posedge clk); #1;
    check("w2b_sigv_mid", 64'(sig_valid), 64'(0));
    check("w2b_cnt_mid", 64'(vec_cnt), 64'(1));
    check("w2b_sig_hold", 64'(sig_out), 64'(30'h5));
    @(posedge clk); #1;
    check("w2b_sigv", 64'(sig_valid), 64'(1));
    check("w2b_sig", 64'(sig_out), 64'(30'h29));
    @(posedge clk); #1;
    check("w2_idle_sigv", 64'(sig_valid), 64'(0));
    check("w2_idle_cnt", 64'(vec_cnt), 64'(0));
    check("w2_pulses", 64'(sig_pulses), 64'(2));
    check("w2_drained", 64'(exp_q.size()), 64'(0));
`else
    do_reset();
    run_stream(0, 3, 1'b1);
    check("nomisr_pulses", 64'(sig_pulses), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
